// File: rtl/ad_frame_ctrl_if.sv
// ad_frame_ctrl_if -- signal bundle between the frame controller and its
// environment. The environment supplies the ADC stream, the host arm level and
// the SPI transmitter status. The controller returns the SPI launch strobe and
// word, and its status flags.
//   adc_data   ADC sample, valid every clk
//   adc_otr    ADC out-of-range flag for the current sample
//   arm        host permits readout while high
//   spi_ready  SPI transmitter idle (1) / busy (0)
//   spi_start  one-cycle pulse launching a word transfer
//   spi_data   word to transmit, stable between spi_start pulses
//   busy       controller not in IDLE
//   frame_done one-cycle pulse after the last word of a frame is acknowledged
// Modports: master = environment side, slave = controller side.
interface ad_frame_ctrl_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_otr;
  logic              arm;
  logic              spi_ready;
  logic              spi_start;
  logic [DATA_W-1:0] spi_data;
  logic              busy;
  logic              frame_done;

  modport master (
    output adc_data, adc_otr, arm, spi_ready,
    input  spi_start, spi_data, busy, frame_done
  );

  modport slave (
    input  adc_data, adc_otr, arm, spi_ready,
    output spi_start, spi_data, busy, frame_done
  );
endinterface

// File: rtl/ad_frame_ctrl.sv
// ad_frame_ctrl -- captures one frame of DEPTH ADC samples (one stored per
// DECIM input samples) into an on-chip buffer, then streams the buffer out
// word by word through an external SPI transmitter, gated by the host arm level.
//
// Ports:
//   clk      sample/system clock, all logic on posedge
//   rst_n    asynchronous active-low reset
//   bus      ad_frame_ctrl_if.slave (ADC stream, arm, SPI handshake, status)
//   otr_cnt  [ADDR_W] count of stored out-of-range samples in the current frame
//            (present only when AD_OTR_COUNT_EN is defined)
//
// Optional feature macro: AD_OTR_COUNT_EN (out-of-range sample counter).
// Without it adc_otr is ignored and otr_cnt does not exist.
module ad_frame_ctrl #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 261,
  parameter int ADDR_W = 9,
  parameter int DECIM  = 1,
  parameter int CONT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ad_frame_ctrl_if.slave    bus
`ifdef AD_OTR_COUNT_EN
  ,
  output logic [ADDR_W-1:0] otr_cnt
`endif
);

  localparam int              DEC_W     = 5;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_ARM,
    S_RD,
    S_SEND,
    S_ACK_LO,
    S_ACK_HI
  } state_t;

  state_t             r_state;
  logic               r_boot;
  logic               r_arm_q;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [DEC_W-1:0]   r_dec;
  logic               r_spi_start;
  logic [DATA_W-1:0]  r_spi_data;
  logic               r_busy;
  logic               r_frame_done;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rd_q;

  logic               w_we;
  logic               w_last_ack;
  logic               w_cap_entry;

  always_comb begin
    w_we       = (r_state == S_CAPTURE) && (r_dec == '0);
    w_last_ack = (r_state == S_ACK_HI) && bus.spi_ready && (r_rd_addr == ADDR_LAST);
    // Capture starts either after reset release, on an arm rising edge in IDLE,
    // or straight after the final acknowledge in continuous mode.
    w_cap_entry = ((r_state == S_IDLE) && (r_boot || (bus.arm && !r_arm_q)))
               || (w_last_ack && (CONT != 0));
  end

  // Frame buffer: no reset, contents of an aborted frame are simply overwritten.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_addr] <= bus.adc_data;
    end
    if (r_state == S_RD) begin
      r_rd_q <= r_mem[r_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_boot       <= 1'b1;
      r_arm_q      <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_dec        <= '0;
      r_spi_start  <= 1'b0;
      r_spi_data   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_arm_q      <= bus.arm;
      r_spi_start  <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: ;

        S_CAPTURE: begin
          r_dec <= (r_dec == DEC_LAST) ? '0 : r_dec + DEC_W'(1);
          if (r_dec == '0) begin
            if (r_wr_addr == ADDR_LAST) begin
              r_state   <= S_WAIT_ARM;
              r_rd_addr <= '0;
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
          end
        end

        S_WAIT_ARM: begin
          if (bus.arm && bus.spi_ready) begin
            r_state <= S_RD;
          end
        end

        S_RD: r_state <= S_SEND;

        S_SEND: begin
          r_spi_data  <= r_rd_q;
          r_spi_start <= 1'b1;
          r_state     <= S_ACK_LO;
        end

        S_ACK_LO: begin
          if (!bus.spi_ready) begin
            r_state <= S_ACK_HI;
          end
        end

        S_ACK_HI: begin
          if (bus.spi_ready) begin
            if (r_rd_addr == ADDR_LAST) begin
              r_frame_done <= 1'b1;
              r_rd_addr    <= '0;
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_state   <= bus.arm ? S_RD : S_WAIT_ARM;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Overrides the IDLE fall-through above when a new capture begins.
      if (w_cap_entry) begin
        r_state   <= S_CAPTURE;
        r_boot    <= 1'b0;
        r_wr_addr <= '0;
        r_dec     <= '0;
        r_busy    <= 1'b1;
      end
    end
  end

  assign bus.spi_start  = r_spi_start;
  assign bus.spi_data   = r_spi_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

`ifdef AD_OTR_COUNT_EN
  localparam int OTR_MAX_I = (DEPTH > (2**ADDR_W) - 1) ? (2**ADDR_W) - 1 : DEPTH;
  localparam logic [ADDR_W-1:0] OTR_MAX = ADDR_W'(OTR_MAX_I);

  logic [ADDR_W-1:0] r_otr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_otr_cnt <= '0;
    end else if (w_cap_entry) begin
      r_otr_cnt <= '0;
    end else if (w_we && bus.adc_otr && (r_otr_cnt != OTR_MAX)) begin
      r_otr_cnt <= r_otr_cnt + ADDR_W'(1);
    end
  end

  assign otr_cnt = r_otr_cnt;
`else
  logic w_unused_otr;
  assign w_unused_otr = bus.adc_otr;
`endif

endmodule
